// File: rtl/fsm_stim_sequencer.sv
// fsm_stim_sequencer
//
// Drives a serial stimulus pattern into a target FSM and records the
// target's response bit by bit. One run proceeds as follows:
//   1. Reset the target for one cycle.
//   2. Shift the pattern out LSB first, one bit per cycle.
//   3. Wait CAP_DLY more cycles so the last response can arrive.
//   4. Pulse done for one cycle.
//
// Parameters
//   WIDTH    maximum pattern length in bits
//   CAP_DLY  cycles from driving w_out to the z_in response (1..4)
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      run request, only looked at in IDLE
//   pattern    stimulus bits, captured when start is accepted
//   len        number of bits to drive (1..WIDTH), captured with pattern
//   z_in       response from the target FSM
//   w_out      serial stimulus to the target FSM
//   fsm_rst_n  active-low reset for the target FSM
//   busy       high whenever a run is in progress
//   done       one-cycle pulse at the end of a run
//   z_capture  captured responses, LSB first, zero above len
//
// Optional feature (define SEQ_CHECK_EN)
//   expected   reference response, captured when start is accepted
//   match      high when the captured response equals expected over len
//              bits; valid from the DONE cycle until the next accepted start

module fsm_stim_sequencer #(
  parameter int WIDTH   = 8,
  parameter int CAP_DLY = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WIDTH-1:0]       pattern,
  input  logic [$clog2(WIDTH):0] len,
  input  logic                   z_in,
  output logic                   w_out,
  output logic                   fsm_rst_n,
  output logic                   busy,
  output logic                   done,
  output logic [WIDTH-1:0]       z_capture
`ifdef SEQ_CHECK_EN
  ,
  input  logic [WIDTH-1:0]       expected,
  output logic                   match
`endif
);

  localparam int LEN_W = $clog2(WIDTH) + 1;
  // The counter runs across RUN and FLUSH, so it must reach WIDTH+CAP_DLY-1.
  localparam int CNT_W = $clog2(WIDTH + CAP_DLY + 1);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    RUN,
    FLUSH,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cap_idx;
  logic             start_ok;
  logic             run_last;
  logic             flush_last;
  logic             cap_en;

  // Out-of-range lengths make the start request invisible.
  assign start_ok   = start && (len != '0) && (len <= LEN_W'(WIDTH));

  // cnt is zero on the first RUN cycle and keeps counting through FLUSH.
  assign run_last   = (cnt == CNT_W'(len_q) - CNT_W'(1));
  assign flush_last = (cnt == CNT_W'(len_q) + CNT_W'(CAP_DLY - 1));

  // Response bit i appears CAP_DLY cycles after stimulus bit i was driven.
  assign cap_en     = ((state == RUN) || (state == FLUSH)) &&
                      (cnt >= CNT_W'(CAP_DLY));
  assign cap_idx    = cnt - CNT_W'(CAP_DLY);

  // The target FSM is reset combinationally with the sequencer.
  // It is also reset for the single CLR cycle of each run.
  assign fsm_rst_n  = reset && (state != CLR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    w_out     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) begin
          state_nxt = CLR;
        end
      end
      CLR: begin
        state_nxt = RUN;
      end
      RUN: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt == CNT_W'(i)) begin
            w_out = pat_q[i];
          end
        end
        if (run_last) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        if (flush_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef SEQ_CHECK_EN
  logic [WIDTH-1:0] exp_q;
  logic [WIDTH-1:0] len_mask;
  logic             match_q;
  logic             cmp;

  always_comb begin
    len_mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      len_mask[i] = (LEN_W'(i) < len_q);
    end
  end

  assign cmp   = (((z_capture ^ exp_q) & len_mask) == '0);

  // Compare live during DONE, when z_capture is complete, then hold.
  assign match = (state == DONE) ? cmp : match_q;
`endif

  // Datapath: latch the request, run the bit counter, collect responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat_q     <= '0;
      len_q     <= '0;
      cnt       <= '0;
      z_capture <= '0;
`ifdef SEQ_CHECK_EN
      exp_q     <= '0;
      match_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start_ok) begin
            pat_q     <= pattern;
            len_q     <= len;
            z_capture <= '0;
`ifdef SEQ_CHECK_EN
            exp_q     <= expected;
            match_q   <= 1'b0;
`endif
          end
        end
        CLR: begin
          cnt       <= '0;
          z_capture <= '0;
        end
        RUN, FLUSH: begin
          cnt <= cnt + CNT_W'(1);
          if (cap_en) begin
            for (int i = 0; i < WIDTH; i++) begin
              if (cap_idx == CNT_W'(i)) begin
                z_capture[i] <= z_in;
              end
            end
          end
        end
        DONE: begin
`ifdef SEQ_CHECK_EN
          match_q <= cmp;
`endif
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_stim_sequencer.sv
// tb_fsm_stim_sequencer
//
// Directed bench for fsm_stim_sequencer with WIDTH=8 and CAP_DLY=2.
// The target FSM is modelled as a pure two-cycle delay from w_out to z_in,
// so the captured response of a run must equal the driven pattern.
// Define SEQ_CHECK_EN to exercise the expected/match ports as well.

module tb_fsm_stim_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic       z_in;
  logic       w_out;
  logic       fsm_rst_n;
  logic       busy;
  logic       done;
  logic [7:0] z_capture;
`ifdef SEQ_CHECK_EN
  logic [7:0] expected = '0;
  logic       match;
`endif

  int vectors = 0;
  int miscompares = 0;

  // Target model: z_in follows w_out two cycles later.
  logic dly1 = 1'b0;
  logic dly2 = 1'b0;
  always @(posedge clk) begin
    dly1 <= w_out;
    dly2 <= dly1;
  end
  assign z_in = dly2;

  always #5 clk = ~clk;

  fsm_stim_sequencer #(
    .WIDTH  (8),
    .CAP_DLY(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .pattern  (pattern),
    .len      (len),
    .z_in     (z_in),
    .w_out    (w_out),
    .fsm_rst_n(fsm_rst_n),
    .busy     (busy),
    .done     (done),
    .z_capture(z_capture)
`ifdef SEQ_CHECK_EN
    ,
    .expected (expected),
    .match    (match)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Launches one run from IDLE and follows it to its done pulse.
  // poke_cyc > 0 raises start with pattern 0 in that cycle of the run.
  // The task returns at the falling edge inside the DONE cycle.
  task automatic applyStimulus(input string tag, input logic [7:0] pat, input logic [3:0] ln,
                               input int poke_cyc, input logic [7:0] exp_cap,
                               input logic [7:0] expv, input logic exp_match);
    int         cyc;
    int         done_cyc;
    int         rst_low;
    logic [7:0] wseq;
    logic [8:0] mask9;
    @(negedge clk);
    checkOutput({tag, "_idle_busy"}, busy, 0);
    checkOutput({tag, "_idle_done"}, done, 0);
    pattern = pat;
    len     = ln;
    start   = 1'b1;
`ifdef SEQ_CHECK_EN
    expected = expv;
`endif
    @(posedge clk);
    cyc      = 0;
    done_cyc = 0;
    rst_low  = 0;
    wseq     = '0;
    while (done_cyc == 0 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == poke_cyc);
      if (cyc == poke_cyc) begin
        pattern = 8'h00;
      end
      if (!fsm_rst_n) rst_low++;
      if (cyc >= 2 && cyc <= int'(ln) + 1) wseq[cyc-2] = w_out;
      if (done) done_cyc = cyc;
    end
    start = 1'b0;
    mask9 = (9'd1 << ln) - 9'd1;
    checkOutput({tag, "_done_cycle"}, done_cyc, int'(ln) + 4);
    checkOutput({tag, "_fsm_rst_cycles"}, rst_low, 1);
    checkOutput({tag, "_w_seq"}, wseq, pat & mask9[7:0]);
    checkOutput({tag, "_z_capture"}, z_capture, exp_cap);
`ifdef SEQ_CHECK_EN
    checkOutput({tag, "_match"}, match, exp_match);
`else
    if (expv != 8'h00 || exp_match) begin
    end
`endif
  endtask

  int busy_seen;
  int rst_seen;
  int done_seen;

  initial begin
    // Reset values while reset is held low.
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_w_out", w_out, 0);
    checkOutput("rst_fsm_rst_n", fsm_rst_n, 0);
    checkOutput("rst_z_capture", z_capture, 0);
`ifdef SEQ_CHECK_EN
    checkOutput("rst_match", match, 0);
`endif
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rel_fsm_rst_n", fsm_rst_n, 1);
    checkOutput("rel_busy", busy, 0);

    // Full-length run, then a short run started right after DONE.
    applyStimulus("a5_len8", 8'hA5, 4'd8, 0, 8'hA5, 8'hA5, 1'b1);
    applyStimulus("ff_len3", 8'hFF, 4'd3, 0, 8'h07, 8'hFF, 1'b1);

    // Illegal lengths with start held high must never leave IDLE.
    @(negedge clk);
    pattern   = 8'hFF;
    len       = 4'd0;
    start     = 1'b1;
    busy_seen = 0;
    rst_seen  = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (!fsm_rst_n) rst_seen++;
    end
    len = 4'd9;
    repeat (3) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (!fsm_rst_n) rst_seen++;
    end
    start = 1'b0;
    checkOutput("bad_len_busy", busy_seen, 0);
    checkOutput("bad_len_fsm_rst", rst_seen, 0);
    checkOutput("bad_len_hold_cap", z_capture, 8'h07);

    // A second start in the middle of RUN is ignored.
    applyStimulus("3c_poke", 8'h3C, 4'd8, 4, 8'h3C, 8'h00, 1'b0);

    // Reset pulled low on the 4th RUN cycle aborts the run.
    @(negedge clk);
    pattern = 8'hA5;
    len     = 4'd8;
    start   = 1'b1;
    repeat (5) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("pre_abort_busy", busy, 1);
    checkOutput("pre_abort_cap", z_capture, 8'h01);
    reset = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_fsm_rst_n", fsm_rst_n, 0);
    checkOutput("abort_cap", z_capture, 0);
    checkOutput("abort_w_out", w_out, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);

    // A fresh start after the abort runs normally.
    applyStimulus("a5_rerun", 8'hA5, 4'd8, 0, 8'hA5, 8'hA4, 1'b0);

    @(negedge clk);
    checkOutput("final_idle_done", done, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fsm_stim_sequencer.md
FSM_STIM_SEQUENCER -- requirements
Module: fsm_stim_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving the maximum pattern length in bits.
REQ-002 SHALL have parameter CAP_DLY, default 2, giving the clock cycles from driving w_out to the sampled z_in response (range 1..4).
REQ-003 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  request to run one sequence; sampled only in IDLE.
REQ-006 SHALL have port pattern  input  WIDTH  stimulus bits, driven LSB first; captured on accepted start.
REQ-007 SHALL have port len  input  clog2(WIDTH)+1  number of bits to drive (1..WIDTH); captured on accepted start.
REQ-008 SHALL have port z_in  input  1  output of the target FSM under sequence.
REQ-009 SHALL have port w_out  output  1  serial stimulus to the target FSM input.
REQ-010 SHALL have port fsm_rst_n  output  1  active-low reset for the target FSM.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a sequence completes.
REQ-013 SHALL have port z_capture  output  WIDTH  captured responses, LSB first, bits at index >= len forced to 0.

Function
- REQ-014 SHALL implement the states IDLE, CLR, RUN, FLUSH and DONE.
- REQ-015 SHALL, in IDLE with start=1 and 1<=len<=WIDTH, latch pattern and len and go to CLR; any other start is ignored.
- REQ-016 SHALL, in CLR, drive fsm_rst_n=0 and w_out=0 for exactly one cycle, clear z_capture, then go to RUN.
- REQ-017 SHALL, in RUN, drive w_out=pattern[k] on the k-th RUN cycle (k=0..len-1), then go to FLUSH.
- REQ-018 SHALL, in FLUSH, drive w_out=0 for exactly CAP_DLY cycles, then go to DONE.
- REQ-019 SHALL write z_capture[i] with z_in sampled at the edge ending cycle (first RUN cycle + i + CAP_DLY), for i=0..len-1.
- REQ-020 SHALL, in DONE, assert done=1 for one cycle and return to IDLE; z_capture holds until the next accepted start.
- REQ-021 SHALL assert done exactly len+CAP_DLY+2 cycles after the clock edge that accepts start.
- REQ-022 SHALL ignore start while busy=1, with no effect on the sequence in progress.
- REQ-023 SHALL accept start=1 in the cycle after DONE, i.e. back-to-back runs with one IDLE cycle.
- REQ-024 SHALL hold fsm_rst_n=1 in every state except CLR while reset is high.
- REQ-025 SHALL use a bit counter wide enough for WIDTH+CAP_DLY with no wrap within a run.

Reset
- REQ-026 SHALL, while reset=0, force the state to IDLE and busy=0, done=0, w_out=0, z_capture=0, and latched pattern/len=0.
- REQ-027 SHALL drive fsm_rst_n=0 combinationally while reset=0, so the target FSM resets along with the sequencer.
- REQ-028 SHALL abort any run when reset is asserted mid-operation, with no done pulse and z_capture cleared.

Configuration
- REQ-029 SHALL, with SEQ_CHECK_EN defined, add input expected[WIDTH] (latched on start) and output match (1 bit).
- REQ-030 SHALL, with SEQ_CHECK_EN defined, set match=1 in the DONE cycle iff z_capture[len-1:0]==expected[len-1:0]; match holds until the next accepted start, and resets to 0.
- REQ-031 SHALL, without SEQ_CHECK_EN defined, have neither the expected nor the match port and leave all other behaviour unchanged.

Verification (bench model: z_in = w_out delayed CAP_DLY=2 cycles, WIDTH=8)
- REQ-032 SHALL cover: start, pattern=8'hA5, len=8 -> fsm_rst_n low one cycle, w_out=1,0,1,0,0,1,0,1, done 12 cycles after start, z_capture=8'hA5.
- REQ-033 SHALL cover: pattern=8'hFF, len=3 -> 3 RUN cycles, done 7 cycles after start, z_capture=8'h07.
- REQ-034 SHALL cover: start held high with len=0, then with len=9 -> no state change, busy stays 0.
- REQ-035 SHALL cover: a second start with pattern=8'h00 during a RUN of 8'h3C -> ignored, z_capture=8'h3C.
- REQ-036 SHALL cover: reset pulled low on the 4th RUN cycle -> immediate IDLE, fsm_rst_n=0, z_capture=0, no done pulse; a new start then runs normally.
- REQ-037 SHALL cover, with SEQ_CHECK_EN defined: expected=8'hA5 -> match=1; expected=8'hA4 -> match=0.
